keypad_emulator: RTL and testbench

- Synthesizable model of the 3x4 keypad, seen from the keypad side of the scan interface.
- Takes key codes through a valid/ready command port and queues them in a small FIFO.
- Watches the column strobes (key_col) from the game's keypad scanner and drives key_row back, as a physical key press would.
- Used for automated board bring-up and scripted game playback without a human at the keypad.

---
 rtl/keypad_emulator.sv | 234 +++++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad-side emulator for a 3x4 scanned keypad: queued key codes are replayed as row returns.
// Optional contact-bounce model at the start of each press: define KEYPAD_EMULATOR_BOUNCE_EN.
module keypad_emulator #(
  parameter int DEPTH          = 4,
  parameter int HOLD_CYCLES    = 250000,
  parameter int GAP_CYCLES     = 250000,
  parameter int TIMEOUT_CYCLES = 125000,
  parameter int CNT_W          = 20
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  ,
  parameter int BOUNCE_HALF    = 2500
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  output logic       busy,
  output logic       key_done,
  output logic       err_timeout,
  output logic       err_code
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT   = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_COL, HOLD, GAP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       tgt_col;
  logic [3:0]       tgt_row;
  logic             load_tgt, set_err_code, set_err_timeout;
  logic [3:0]       row_next;
  logic             done_next;
  logic             col_match;
  logic             bnc_gate;

  // ---------------------------------------------------------------- command FIFO
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;
  logic [3:0]       head;

  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];

  // NOTE: non-blocking assignments in every clocked block, so all flops update from pre-edge values.
  // NOTE: the storage array is deliberately not reset; count/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_key;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- key map
  logic [2:0] head_col;
  logic [3:0] head_row;
  logic       head_legal;

  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    head_legal = 1'b1;
    head_col   = '0;
    head_row   = '0;
    case (head)
      4'd1:    {head_col, head_row} = {3'b001, 4'b0001};
      4'd4:    {head_col, head_row} = {3'b001, 4'b0010};
      4'd7:    {head_col, head_row} = {3'b001, 4'b0100};
      4'd10:   {head_col, head_row} = {3'b001, 4'b1000};
      4'd2:    {head_col, head_row} = {3'b010, 4'b0001};
      4'd5:    {head_col, head_row} = {3'b010, 4'b0010};
      4'd8:    {head_col, head_row} = {3'b010, 4'b0100};
      4'd0:    {head_col, head_row} = {3'b010, 4'b1000};
      4'd3:    {head_col, head_row} = {3'b100, 4'b0001};
      4'd6:    {head_col, head_row} = {3'b100, 4'b0010};
      4'd9:    {head_col, head_row} = {3'b100, 4'b0100};
      4'd11:   {head_col, head_row} = {3'b100, 4'b1000};
      default: head_legal = 1'b0;
    endcase
  end

  // Target column is always one-hot once loaded, so idle or multi-bit strobes never match.
  assign col_match = (key_col == tgt_col);

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tgt_col     <= '0;
      tgt_row     <= '0;
      key_row     <= '0;
      key_done    <= 1'b0;
      err_timeout <= 1'b0;
      err_code    <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      key_row  <= row_next;
      key_done <= done_next;
      if (load_tgt) begin
        tgt_col <= head_col;
        tgt_row <= head_row;
      end
      if (set_err_timeout) err_timeout <= 1'b1;
      if (set_err_code)    err_code    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    load_tgt        = 1'b0;
    set_err_code    = 1'b0;
    set_err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          if (head_legal) begin
            load_tgt   = 1'b1;
            cnt_next   = '0;
            state_next = WAIT_COL;
          end else begin
            set_err_code = 1'b1;
          end
        end
      end
      WAIT_COL: begin
        if (col_match) begin
          cnt_next   = '0;
          state_next = HOLD;
        end else if (cnt == TIMEOUT_LAST) begin
          set_err_timeout = 1'b1;
          cnt_next        = '0;
          state_next      = GAP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- contact bounce
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'(BOUNCE_HALF - 1);

  // bnc_idx walks 0..7 through the on/off half-periods; 8 means the contact has settled.
  logic [CNT_W-1:0] bnc_cnt, bnc_cnt_next;
  logic [3:0]       bnc_idx, bnc_idx_next;

  always_comb begin
    bnc_cnt_next = bnc_cnt;
    bnc_idx_next = bnc_idx;
    if (state != HOLD) begin
      bnc_cnt_next = '0;
      bnc_idx_next = '0;
    end else if (!bnc_idx[3]) begin
      if (bnc_cnt == BNC_LAST) begin
        bnc_cnt_next = '0;
        bnc_idx_next = bnc_idx + 1'b1;
      end else begin
        bnc_cnt_next = bnc_cnt + 1'b1;
      end
    end
    bnc_gate = bnc_idx_next[3] || !bnc_idx_next[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bnc_cnt <= '0;
      bnc_idx <= '0;
    end else begin
      bnc_cnt <= bnc_cnt_next;
      bnc_idx <= bnc_idx_next;
    end
  end
`else
  assign bnc_gate = 1'b1;
`endif

  // ---------------------------------------------------------------- FSM: outputs
  // key_row is loaded for the cycle ahead, so a column match shows up one clock later and
  // the row is already low in the first GAP cycle.
  always_comb begin
    row_next = '0;
    if (state_next == HOLD && col_match && bnc_gate) row_next = tgt_row;
    done_next = (state == GAP) && (state_next == IDLE);
    busy      = (count != '0) || (state != IDLE);
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: queue-based behavioural model plus directed pins
// and a randomized command/strobe phase.
module tb_keypad_emulator;

  localparam int DEPTH = 4;
  localparam int HOLD  = 20;
  localparam int GAP   = 10;
  localparam int TMO   = 30;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_HOLD = 2;
  localparam int P_GAP  = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_key   = 4'd0;
  logic       busy, key_done, err_timeout, err_code;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // key_col source: 0 = manual, 1 = rotating every 8 cycles, 2 = random patterns
  int         col_mode   = 0;
  logic [2:0] col_manual = 3'b000;
  logic [2:0] col_rot    = 3'b001;
  logic [2:0] col_rnd    = 3'b000;

  keypad_emulator #(
    .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .busy(busy), .key_done(key_done), .err_timeout(err_timeout), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always_comb key_col = (col_mode == 1) ? col_rot : (col_mode == 2) ? col_rnd : col_manual;

  initial begin
    int rot_cnt;
    int rnd_left;
    logic [2:0] pats [7];
    pats = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b111, 3'b110};
    rot_cnt  = 0;
    rnd_left = 0;
    forever begin
      @(negedge clk);
      rot_cnt++;
      if (rot_cnt == 8) begin
        rot_cnt = 0;
        col_rot = {col_rot[1:0], col_rot[2]};
      end
      if (rnd_left == 0) begin
        col_rnd  = pats[$urandom_range(0, 6)];
        rnd_left = $urandom_range(1, 6);
      end else begin
        rnd_left--;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keypad layout: digits 1..9 fill a 3x3 grid row by row; bottom row is '*', 0, '#'.
  function automatic void key_map(input int k, output logic [2:0] col, output logic [3:0] row);
    int c, r;
    if (k >= 1 && k <= 9) begin
      c = (k - 1) % 3;
      r = (k - 1) / 3;
    end else begin
      r = 3;
      c = (k == 10) ? 0 : (k == 0) ? 1 : 2;
    end
    col = 3'(1 << c);
    row = 4'(1 << r);
  endfunction

  // ---------------------------------------------------------------- behavioural model
  int         m_q[$];
  int         m_phase = P_IDLE;
  int         m_left  = 0;
  logic [2:0] m_col   = '0;
  logic [3:0] m_mask  = '0;
  logic [3:0] m_row   = '0;
  bit         m_done  = 1'b0;
  bit         m_errt  = 1'b0;
  bit         m_errc  = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_q.delete();
      m_phase = P_IDLE;
      m_left  = 0;
      m_row   = '0;
      m_done  = 1'b0;
      m_errt  = 1'b0;
      m_errc  = 1'b0;
    end else begin
      bit acc;
      int k;
      acc    = cmd_valid && (m_q.size() != DEPTH);
      m_row  = '0;
      m_done = 1'b0;
      case (m_phase)
        P_IDLE: if (m_q.size() != 0) begin
          k = m_q.pop_front();
          if (k > 11) m_errc = 1'b1;
          else begin
            key_map(k, m_col, m_mask);
            m_phase = P_WAIT;
            m_left  = TMO;
          end
        end
        P_WAIT: begin
          if (key_col == m_col) begin
            m_phase = P_HOLD;
            m_left  = HOLD;
            m_row   = m_mask;
          end else if (m_left == 1) begin
            m_errt  = 1'b1;
            m_phase = P_GAP;
            m_left  = GAP;
          end else begin
            m_left--;
          end
        end
        P_HOLD: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = P_GAP;
            m_left  = GAP;
          end else if (key_col == m_col) begin
            m_row = m_mask;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = P_IDLE;
            m_done  = 1'b1;
          end
        end
      endcase
      if (acc) m_q.push_back(int'(cmd_key));
    end
  end

  // ---------------------------------------------------------------- compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("key_row",     key_row,     m_row);
      check("cmd_ready",   cmd_ready,   m_q.size() != DEPTH);
      check("busy",        busy,        (m_q.size() != 0) || (m_phase != P_IDLE));
      check("key_done",    key_done,    m_done);
      check("err_timeout", err_timeout, m_errt);
      check("err_code",    err_code,    m_errc);
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic do_reset();
    cmd_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push(input logic [3:0] k);
    cmd_valid = 1'b1;
    cmd_key   = k;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    int n, len, g, seen, bad, dones;
    logic [3:0] codes [5];

    // Reset values
    do_reset();
    chk_en = 1'b1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_key_row", key_row, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_key_done", key_done, 1'b0);
    check("rst_err_timeout", err_timeout, 1'b0);
    check("rst_err_code", err_code, 1'b0);

    // Key 5, column 2 strobed from the third cycle
    col_mode = 0;
    col_manual = 3'b000;
    push(4'd5);
    repeat (2) @(negedge clk);
    col_manual = 3'b010;
    n = 0;
    while (key_row == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_row_value", key_row, 4'b0010);
    len = 0;
    while (key_row == 4'b0010 && len < 100) begin
      len++;
      @(negedge clk);
    end
    check("t1_hold_len", len, HOLD);
    g = 0;
    while (!key_done && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("t1_gap_len", g, GAP);
    check("t1_busy_after", busy, 1'b0);

    // '#' under a rotating scanner: row only while column 3 is strobed
    do_reset();
    col_mode = 1;
    push(4'd11);
    seen = 0;
    bad = 0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
      if (key_row == 4'b1000) seen++;
      else if (key_row != 4'b0000) bad++;
    end
    check("t2_drained", busy, 1'b0);
    check("t2_row_seen", seen > 0, 1'b1);
    check("t2_wrong_row", bad, 0);

    // Fill the FIFO while the first key waits on an idle scanner
    do_reset();
    col_mode = 0;
    col_manual = 3'b000;
    codes = '{4'd1, 4'd5, 4'd9, 4'd0, 4'd7};
    for (int i = 0; i < 5; i++) push(codes[i]);
    check("t3_full", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_key = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_still_full", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    col_mode = 1;
    dones = 0;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
      if (key_done) dones++;
    end
    check("t3_drained", busy, 1'b0);
    check("t3_key_count", dones, 5);
    check("t3_no_timeout", err_timeout, 1'b0);

    // Key 7 while only column 2 is strobed: timeout, no press
    do_reset();
    col_mode = 0;
    col_manual = 3'b010;
    push(4'd7);
    n = 1;
    while (!err_timeout && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_latency", n, TMO + 2);
    g = 0;
    while (!key_done && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("t4_gap_len", g, GAP);

    // Illegal code followed by key 2
    do_reset();
    col_manual = 3'b010;
    push(4'd13);
    push(4'd2);
    n = 0;
    while (key_row == 4'b0000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t5_row_value", key_row, 4'b0001);
    check("t5_err_code", err_code, 1'b1);
    drain("t5_drained", 200);

    // Asynchronous reset in the middle of a press
    do_reset();
    col_manual = 3'b001;
    push(4'd12);
    push(4'd7);
    n = 0;
    while (key_row != 4'b0100 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_row_value", key_row, 4'b0100);
    repeat (3) @(negedge clk);
    check("t6_err_code_set", err_code, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_row", key_row, 4'b0000);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_ready", cmd_ready, 1'b1);
    check("t6_async_err_code", err_code, 1'b0);
    check("t6_async_err_timeout", err_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized commands against random column patterns
    do_reset();
    col_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_key = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    drain("rand_drained", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
